// File: rtl/ui_pkg.sv
// Shared types and constants for the user interface controller:
// FSM state encoding, application command codes and idle-menu indices.
package ui_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INCOMING  = 3'd1,
        S_OUTGOING  = 3'd2,
        S_BUSY      = 3'd3,
        S_CALL_WAIT = 3'd4,
        S_INIT      = 3'd5
    } ui_state_e;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_INIT      = 3'd1;
    localparam logic [2:0] CMD_MAKE_CALL = 3'd2;
    localparam logic [2:0] CMD_ACCEPT    = 3'd3;
    localparam logic [2:0] CMD_REJECT    = 3'd4;
    localparam logic [2:0] CMD_END_CALL  = 3'd5;
    localparam logic [2:0] CMD_HOLD      = 3'd6;

    localparam int unsigned MENU_CALL  = 0;
    localparam int unsigned MENU_BLOCK = 1;

endpackage

// File: rtl/user_interface_ctrl_if.sv
// Command channel from the UI controller to the application layer
// (valid/ready handshake carrying a command code and target address).
interface user_interface_ctrl_if #(
    parameter int ADDR_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_code;
    logic [ADDR_W-1:0] cmd_addr;

    modport master (output cmd_valid, output cmd_code, output cmd_addr, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, input cmd_addr, output cmd_ready);

endinterface

// File: rtl/ui_block_list.sv
// Circular blocked-caller list: append overwrites the oldest entry when full,
// clear empties it, lookup is a single-cycle compare against all valid entries.
module ui_block_list #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              add,
    input  logic              clear,
    input  logic [ADDR_W-1:0] add_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] entry [DEPTH];
    logic [DEPTH-1:0]  used;
    logic [PW-1:0]     wr_ptr;

    // Entry contents need no reset: the used bits gate every compare.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            used   <= '0;
            wr_ptr <= '0;
        end else if (add) begin
            entry[wr_ptr] <= add_addr;
            used[wr_ptr]  <= 1'b1;
            wr_ptr        <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (used[i] && entry[i] == lookup_addr) hit = 1'b1;
        end
    end

endmodule

// File: rtl/user_interface_ctrl.sv
// Telephone-style UI controller: buttons and network events drive a call FSM
// that issues commands over a valid/ready channel. Optional caller blocking: UI_CALL_BLOCK_EN.
module user_interface_ctrl
    import ui_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int MENU_ITEMS   = 7,
    parameter int BLOCK_DEPTH  = 4,
    parameter int RING_TIMEOUT = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         btn_enter,
    input  logic [ADDR_W-1:0]            dial_addr,
    input  logic                         init_done,
    input  logic                         inc_call,
    input  logic [ADDR_W-1:0]            inc_addr,
    input  logic                         remote_ack,
    input  logic                         remote_hangup,
    user_interface_ctrl_if.master        cmd,
    output logic [2:0]                   state,
    output logic [5:0]                   menu_item,
    output logic                         blocked_hit
);

    localparam int RW = $clog2(RING_TIMEOUT + 1);

    if (MENU_ITEMS < 2 || MENU_ITEMS > 64 || BLOCK_DEPTH < 1 ||
        (BLOCK_DEPTH & (BLOCK_DEPTH - 1)) != 0 || RING_TIMEOUT < 1) begin : g_bad_param
        $error("user_interface_ctrl: illegal parameter value");
    end

    ui_state_e         fsm_state;
    logic [RW-1:0]     ring_cnt;
    logic [ADDR_W-1:0] peer_addr;
    logic [ADDR_W-1:0] wait_addr;
    logic              pend_call;
    logic              hold_chain;
    logic              accepted;
    logic              slot_free;
    logic              btn_ok;
    logic              ringing;
    logic              ring_done;
    logic              list_hit;
    logic              blocked_call;

    assign state        = fsm_state;
    assign accepted     = cmd.cmd_valid && cmd.cmd_ready;
    // A chained HOLD->ACCEPT reloads the channel on its accept cycle, so it is not free then.
    assign slot_free    = !cmd.cmd_valid || (cmd.cmd_ready && !hold_chain);
    assign btn_ok       = !cmd.cmd_valid;
    assign ringing      = (fsm_state == S_INCOMING) || (fsm_state == S_OUTGOING);
    assign ring_done    = (ring_cnt == RW'(RING_TIMEOUT - 1));
    assign blocked_call = inc_call && list_hit && (fsm_state != S_INIT);

`ifdef UI_CALL_BLOCK_EN
    logic blk_add;
    logic blk_clear;

    always_comb begin
        blk_add   = 1'b0;
        blk_clear = 1'b0;
        if (fsm_state == S_IDLE && !inc_call && btn_ok && menu_item == 6'(MENU_BLOCK)) begin
            blk_add   = btn_enter || btn_right;
            blk_clear = !(btn_enter || btn_right) && btn_left;
        end
    end

    ui_block_list #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BLOCK_DEPTH)
    ) u_block_list (
        .clk         (clk),
        .reset       (reset),
        .add         (blk_add),
        .clear       (blk_clear),
        .add_addr    (dial_addr),
        .lookup_addr (inc_addr),
        .hit         (list_hit)
    );
`else
    assign list_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state     <= S_INIT;
            menu_item     <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_code  <= CMD_NOP;
            cmd.cmd_addr  <= '0;
            blocked_hit   <= 1'b0;
            ring_cnt      <= '0;
            peer_addr     <= '0;
            wait_addr     <= '0;
            pend_call     <= 1'b0;
            hold_chain    <= 1'b0;
        end else begin
            blocked_hit <= blocked_call;
            // menu_item only moves in IDLE, so holding it at 0 elsewhere resets it on every IDLE entry.
            if (fsm_state != S_IDLE) menu_item <= '0;
            if (!ringing)        ring_cnt <= '0;
            else if (!ring_done) ring_cnt <= ring_cnt + 1'b1;

            if (accepted) begin
                cmd.cmd_valid <= 1'b0;
                if (hold_chain) begin
                    {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_ACCEPT, wait_addr};
                    peer_addr  <= wait_addr;
                    hold_chain <= 1'b0;
                    fsm_state  <= S_BUSY;
                end
                if (pend_call) begin
                    pend_call <= 1'b0;
                    peer_addr <= cmd.cmd_addr;
                    fsm_state <= S_OUTGOING;
                end
            end

            // Automatic rejects are dropped when the channel is still occupied.
            if (blocked_call) begin
                if (slot_free) {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_REJECT, inc_addr};
            end else if (inc_call && (fsm_state == S_INCOMING || fsm_state == S_OUTGOING ||
                                      fsm_state == S_CALL_WAIT)) begin
                if (slot_free) {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_REJECT, inc_addr};
            end else begin
                case (fsm_state)
                    S_INIT: begin
                        if (init_done) fsm_state <= S_IDLE;
                        else if (btn_ok && btn_enter)
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_INIT, {ADDR_W{1'b0}}};
                    end
                    S_IDLE: begin
                        if (inc_call) begin
                            fsm_state <= S_INCOMING;
                            peer_addr <= inc_addr;
                            pend_call <= 1'b0;
                        end else if (btn_ok) begin
                            if (btn_enter || btn_right) begin
                                if (menu_item == 6'(MENU_CALL)) begin
                                    {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_MAKE_CALL, dial_addr};
                                    pend_call <= 1'b1;
                                end
                            end else if (!btn_left) begin
                                if (btn_up)
                                    menu_item <= (menu_item == '0) ? 6'(MENU_ITEMS - 1) : menu_item - 1'b1;
                                else if (btn_down)
                                    menu_item <= (menu_item == 6'(MENU_ITEMS - 1)) ? '0 : menu_item + 1'b1;
                            end
                        end
                    end
                    S_INCOMING: begin
                        if (ring_done && slot_free) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_REJECT, peer_addr};
                            fsm_state <= S_IDLE;
                        end else if (btn_ok && btn_enter) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_ACCEPT, peer_addr};
                            fsm_state <= S_BUSY;
                        end else if (btn_ok && btn_left) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_REJECT, peer_addr};
                            fsm_state <= S_IDLE;
                        end
                    end
                    S_OUTGOING: begin
                        if (remote_ack) fsm_state <= S_BUSY;
                        else if ((ring_done && slot_free) || (btn_ok && btn_left)) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_END_CALL, peer_addr};
                            fsm_state <= S_IDLE;
                        end
                    end
                    S_BUSY: begin
                        if (inc_call) begin
                            fsm_state <= S_CALL_WAIT;
                            wait_addr <= inc_addr;
                        end else if (remote_hangup) fsm_state <= S_IDLE;
                        else if (btn_ok && btn_left) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_END_CALL, peer_addr};
                            fsm_state <= S_IDLE;
                        end
                    end
                    S_CALL_WAIT: begin
                        if (remote_hangup) begin
                            fsm_state  <= S_INCOMING;
                            peer_addr  <= wait_addr;
                            hold_chain <= 1'b0;
                        end else if (btn_ok && btn_left) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_REJECT, wait_addr};
                            fsm_state <= S_BUSY;
                        end else if (btn_ok && btn_enter) begin
                            {cmd.cmd_valid, cmd.cmd_code, cmd.cmd_addr} <= {1'b1, CMD_HOLD, peer_addr};
                            hold_chain <= 1'b1;
                        end
                    end
                    default: fsm_state <= S_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_user_interface_ctrl.sv
// Scoreboard bench for user_interface_ctrl: expected commands are queued as
// stimulus is driven and compared as each command transfers on the channel.
module tb_user_interface_ctrl;
    import ui_pkg::*;

    localparam int ADDR_W       = 8;
    localparam int MENU_ITEMS   = 7;
    localparam int RING_TIMEOUT = 1000;
    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_ENTER = 4;

    typedef struct packed {
        logic [2:0]        code;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_up, btn_down, btn_left, btn_right, btn_enter;
    logic [ADDR_W-1:0] dial_addr, inc_addr;
    logic              init_done, inc_call, remote_ack, remote_hangup;
    logic [2:0]        state;
    logic [5:0]        menu_item;
    logic              blocked_hit;

    cmd_t exp_q[$];
    cmd_t mon_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    user_interface_ctrl_if #(.ADDR_W(ADDR_W)) cmd_if ();

    user_interface_ctrl #(
        .ADDR_W       (ADDR_W),
        .MENU_ITEMS   (MENU_ITEMS),
        .BLOCK_DEPTH  (4),
        .RING_TIMEOUT (RING_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_enter     (btn_enter),
        .dial_addr     (dial_addr),
        .init_done     (init_done),
        .inc_call      (inc_call),
        .inc_addr      (inc_addr),
        .remote_ack    (remote_ack),
        .remote_hangup (remote_hangup),
        .cmd           (cmd_if.master),
        .state         (state),
        .menu_item     (menu_item),
        .blocked_hit   (blocked_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfer happens at the next rising edge; sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("cmd_unexpected_qsize", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cmd_code_addr", {21'd0, cmd_if.cmd_code, cmd_if.cmd_addr}, {21'd0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        btn_up    = (b == B_UP);
        btn_down  = (b == B_DOWN);
        btn_left  = (b == B_LEFT);
        btn_right = (b == B_RIGHT);
        btn_enter = (b == B_ENTER);
        tick();
        {btn_up, btn_down, btn_left, btn_right, btn_enter} = '0;
    endtask

    task automatic pulse_inc(input logic [ADDR_W-1:0] a);
        inc_call = 1'b1;
        inc_addr = a;
        tick();
        inc_call = 1'b0;
    endtask

    task automatic expect_cmd(input logic [2:0] code, input logic [ADDR_W-1:0] addr);
        exp_q.push_back({code, addr});
    endtask

    task automatic drain();
        int n = 0;
        while (cmd_if.cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check("cmd_drain", 32'(cmd_if.cmd_valid), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        {btn_up, btn_down, btn_left, btn_right, btn_enter} = '0;
        dial_addr = '0; inc_addr = '0;
        init_done = 1'b0; inc_call = 1'b0; remote_ack = 1'b0; remote_hangup = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        repeat (3) tick();

        check("rst_state", state, 32'(S_INIT));
        check("rst_menu", menu_item, 0);
        check("rst_valid", cmd_if.cmd_valid, 0);
        check("rst_code", cmd_if.cmd_code, 32'(CMD_NOP));
        check("rst_addr", cmd_if.cmd_addr, 0);
        check("rst_blocked", blocked_hit, 0);

        reset = 1'b0;
        tick();
        expect_cmd(CMD_INIT, 8'h00);
        press(B_ENTER);
        check("init_stays", state, 32'(S_INIT));
        drain();

        init_done = 1'b1;
        tick();
        check("idle_state", state, 32'(S_IDLE));
        check("idle_menu", menu_item, 0);
        check("idle_valid", cmd_if.cmd_valid, 0);

        press(B_UP);
        check("menu_wrap_up", menu_item, 32'(MENU_ITEMS - 1));
        press(B_DOWN);
        check("menu_wrap_down", menu_item, 0);

        // MAKE_CALL held stable under backpressure
        cmd_if.cmd_ready = 1'b0;
        dial_addr = 8'h3C;
        expect_cmd(CMD_MAKE_CALL, 8'h3C);
        press(B_ENTER);
        dial_addr = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("mk_valid", cmd_if.cmd_valid, 1);
            check("mk_code_addr", {cmd_if.cmd_code, cmd_if.cmd_addr}, {CMD_MAKE_CALL, 8'h3C});
            tick();
        end
        check("mk_still_idle", state, 32'(S_IDLE));
        cmd_if.cmd_ready = 1'b1;
        tick();
        check("mk_outgoing", state, 32'(S_OUTGOING));

        // unanswered ring times out
        expect_cmd(CMD_END_CALL, 8'h3C);
        n = 0;
        while (state == 3'(S_OUTGOING) && n < RING_TIMEOUT + 100) begin
            tick();
            n++;
        end
        check("ring_timeout_cycles", n, RING_TIMEOUT);
        check("ring_timeout_state", state, 32'(S_IDLE));
        drain();

        dial_addr = 8'h47;
        expect_cmd(CMD_MAKE_CALL, 8'h47);
        press(B_RIGHT);
        tick();
        check("call2_outgoing", state, 32'(S_OUTGOING));
        remote_ack = 1'b1; tick(); remote_ack = 1'b0;
        check("call2_busy", state, 32'(S_BUSY));

        pulse_inc(8'h11);
        check("cw_enter", state, 32'(S_CALL_WAIT));
        expect_cmd(CMD_REJECT, 8'h11);
        press(B_LEFT);
        check("cw_reject_busy", state, 32'(S_BUSY));
        drain();

        pulse_inc(8'h33);
        check("cw2_enter", state, 32'(S_CALL_WAIT));
        expect_cmd(CMD_HOLD, 8'h47);
        expect_cmd(CMD_ACCEPT, 8'h33);
        press(B_ENTER);
        tick();
        check("cw_chain_valid", cmd_if.cmd_valid, 1);
        check("cw_chain_code", cmd_if.cmd_code, 32'(CMD_ACCEPT));
        check("cw_chain_busy", state, 32'(S_BUSY));
        drain();

        remote_hangup = 1'b1; tick(); remote_hangup = 1'b0;
        check("hangup_idle", state, 32'(S_IDLE));

        pulse_inc(8'h5A);
        check("inc_state", state, 32'(S_INCOMING));
        expect_cmd(CMD_REJECT, 8'h66);
        pulse_inc(8'h66);
        check("inc_auto_reject_state", state, 32'(S_INCOMING));
        drain();
        expect_cmd(CMD_ACCEPT, 8'h5A);
        press(B_ENTER);
        check("inc_accept_busy", state, 32'(S_BUSY));
        drain();
        expect_cmd(CMD_END_CALL, 8'h5A);
        press(B_LEFT);
        check("busy_end_idle", state, 32'(S_IDLE));
        drain();

        press(B_DOWN);
        press(B_DOWN);
        check("menu_item2", menu_item, 2);
        press(B_ENTER);
        check("item2_noop_valid", cmd_if.cmd_valid, 0);
        press(B_DOWN);
        check("menu_item3", menu_item, 3);
        pulse_inc(8'h70);
        check("inc2_state", state, 32'(S_INCOMING));
        expect_cmd(CMD_REJECT, 8'h70);
        press(B_LEFT);
        check("inc_reject_idle", state, 32'(S_IDLE));
        check("menu_reset_on_idle", menu_item, 0);
        drain();

        // inc_call outranks remote_ack in the same cycle
        dial_addr = 8'h12;
        expect_cmd(CMD_MAKE_CALL, 8'h12);
        press(B_ENTER);
        tick();
        check("call3_outgoing", state, 32'(S_OUTGOING));
        expect_cmd(CMD_REJECT, 8'h13);
        inc_call = 1'b1; inc_addr = 8'h13; remote_ack = 1'b1;
        tick();
        inc_call = 1'b0; remote_ack = 1'b0;
        check("prio_state", state, 32'(S_OUTGOING));
        drain();
        remote_ack = 1'b1; tick(); remote_ack = 1'b0;
        check("call3_busy", state, 32'(S_BUSY));
        expect_cmd(CMD_END_CALL, 8'h12);
        press(B_LEFT);
        check("call3_idle", state, 32'(S_IDLE));
        drain();

`ifdef UI_CALL_BLOCK_EN
        press(B_DOWN);
        check("blk_menu1", menu_item, 1);
        dial_addr = 8'h22;
        press(B_ENTER);
        check("blk_add_novalid", cmd_if.cmd_valid, 0);
        expect_cmd(CMD_REJECT, 8'h22);
        pulse_inc(8'h22);
        check("blk_hit_pulse", blocked_hit, 1);
        check("blk_state_idle", state, 32'(S_IDLE));
        tick();
        check("blk_hit_clear", blocked_hit, 0);
        drain();
        press(B_LEFT);
        pulse_inc(8'h22);
        check("blk_cleared_incoming", state, 32'(S_INCOMING));
        check("blk_cleared_nohit", blocked_hit, 0);
        expect_cmd(CMD_REJECT, 8'h22);
        press(B_LEFT);
        check("blk_reject_idle", state, 32'(S_IDLE));
        drain();
`endif

        // reset while a command is pending abandons it
        cmd_if.cmd_ready = 1'b0;
        dial_addr = 8'h44;
        press(B_ENTER);
        check("mid_pending_valid", cmd_if.cmd_valid, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", cmd_if.cmd_valid, 0);
        check("mid_rst_state", state, 32'(S_INIT));
        reset = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_state", state, 32'(S_IDLE));
        check("post_rst_valid", cmd_if.cmd_valid, 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
